pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register for the pipelined core. It is the generic successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle under a valid/ready handshake, with synchronous flush (bubble insertion) and an optional skid entry that registers the upstream ready path. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 159 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Valid/ready pipeline-stage register with flush, optional skid
//            entry and saturating stall-cycle counter.
// Revision : 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int CTRL_W  = 8,
  parameter int DATA_W  = 128,
  parameter int SKID    = 1,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  input  logic               clr_stats,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [1:0] c_st_empty = 2'd0;
  localparam logic [1:0] c_st_full  = 2'd1;
  localparam logic [1:0] c_st_both  = 2'd2;
  localparam logic [STALL_W-1:0] c_stall_max = '1;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CTRL_W-1:0]  r_main_ctrl;
  logic [DATA_W-1:0]  r_main_data;
  logic [CTRL_W-1:0]  w_skid_ctrl;
  logic [DATA_W-1:0]  w_skid_data;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               w_out_valid;
  logic               w_in_ready;
  logic               w_in_xfer;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;

  assign w_out_valid = (r_state != c_st_empty);
  assign w_in_xfer   = in_valid & w_in_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_in_ready;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;

      // in_ready is registered so the upstream ready path starts at a flop
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_in_ready  <= 1'b1;
          r_skid_ctrl <= '0;
          r_skid_data <= '0;
        end else begin
          r_in_ready <= (w_state_nxt != c_st_both);
          if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
          end
        end
      end

      assign w_in_ready  = r_in_ready;
      assign w_skid_ctrl = r_skid_ctrl;
      assign w_skid_data = r_skid_data;
    end else begin : g_no_skid
      assign w_in_ready  = !w_out_valid | out_ready;
      assign w_skid_ctrl = '0;
      assign w_skid_data = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_empty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = c_st_empty;
    end else begin
      case (r_state)
        c_st_empty: begin
          if (w_in_xfer) begin
            w_state_nxt    = c_st_full;
            w_load_main_in = 1'b1;
          end
        end
        c_st_full: begin
          if (w_in_xfer && out_ready) begin
            w_load_main_in = 1'b1;
          end else if (w_in_xfer) begin
            // only reachable with the skid entry present
            w_state_nxt = c_st_both;
            w_load_skid = 1'b1;
          end else if (out_ready) begin
            w_state_nxt = c_st_empty;
          end
        end
        c_st_both: begin
          if (out_ready) begin
            w_state_nxt      = c_st_full;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = c_st_empty;
      endcase
    end
  end

  always_comb begin
    out_valid = w_out_valid;
    out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    out_data  = r_main_data;
    in_ready  = w_in_ready;
    stall_cnt = r_stall_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else if (w_load_main_in) begin
      r_main_ctrl <= in_ctrl;
      r_main_data <= in_data;
    end else if (w_load_main_skid) begin
      r_main_ctrl <= w_skid_ctrl;
      r_main_data <= w_skid_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (clr_stats) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && (r_stall_cnt != c_stall_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Checks a SKID=1 and a SKID=0 instance against a queue model.
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        clr_stats = 1'b0;
  logic        out_ready1 = 1'b0;
  logic        out_ready0 = 1'b0;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [7:0]  out_ctrl1, out_ctrl0;
  logic [31:0] out_data1, out_data0;
  logic [3:0]  stall1, stall0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(1), .STALL_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .clr_stats(clr_stats), .stall_cnt(stall1)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(0), .STALL_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .clr_stats(clr_stats), .stall_cnt(stall0)
  );

  // Reference model: each stage is a FIFO of beats with capacity 2 (skid) or 1
  logic [39:0] q1[$];
  logic [39:0] q0[$];
  int          st1 = 0, st0 = 0;
  logic [31:0] last1 = '0, last0 = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ir1, ov1, ir0, ov0;
    ir1 = (q1.size() < 2);
    ov1 = (q1.size() != 0);
    ir0 = (q0.size() == 0) || out_ready0;
    ov0 = (q0.size() != 0);
    if (clr_stats) st1 = 0; else if (ov1 && !out_ready1 && st1 < 15) st1++;
    if (clr_stats) st0 = 0; else if (ov0 && !out_ready0 && st0 < 15) st0++;
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (ov1 && out_ready1) void'(q1.pop_front());
      if (in_valid && ir1) q1.push_back({in_ctrl, in_data});
      if (ov0 && out_ready0) void'(q0.pop_front());
      if (in_valid && ir0) q0.push_back({in_ctrl, in_data});
    end
    if (q1.size() != 0) last1 = q1[0][31:0];
    if (q0.size() != 0) last0 = q0[0][31:0];
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        q1.delete(); q0.delete();
        st1 = 0; st0 = 0;
        last1 = '0; last0 = '0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("m1_valid", out_valid1, q1.size() != 0);
      chk("m1_ctrl",  out_ctrl1,  (q1.size() != 0) ? q1[0][39:32] : 8'h00);
      chk("m1_data",  out_data1,  (q1.size() != 0) ? q1[0][31:0] : last1);
      chk("m1_ready", in_ready1,  q1.size() < 2);
      chk("m1_stall", stall1,     st1);
      chk("m0_valid", out_valid0, q0.size() != 0);
      chk("m0_ctrl",  out_ctrl0,  (q0.size() != 0) ? q0[0][39:32] : 8'h00);
      chk("m0_data",  out_data0,  (q0.size() != 0) ? q0[0][31:0] : last0);
      chk("m0_ready", in_ready0,  (q0.size() == 0) || out_ready0);
      chk("m0_stall", stall0,     st0);
    end
  end

  // Drives one cycle of stimulus at the falling edge; returns just after
  task automatic tick(input bit v, input logic [7:0] c, input logic [31:0] d,
                      input bit r1, input bit r0, input bit fl, input bit cl);
    @(negedge clk);
    in_valid   = v;
    in_ctrl    = c;
    in_data    = d;
    out_ready1 = r1;
    out_ready0 = r0;
    flush      = fl;
    clr_stats  = cl;
    #2;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("rst_valid1", out_valid1, 1'b0);
    chk("rst_ready1", in_ready1, 1'b1);
    chk("rst_ready0", in_ready0, 1'b1);
    chk("rst_data1",  out_data1, 32'h0);

    // streaming at full throughput
    for (int i = 0; i < 9; i++) begin
      tick(i < 8, 8'h01, 32'h10 + i, 1'b1, 1'b1, 1'b0, 1'b0);
      if (i > 0) begin
        chk("stream_data1",  out_data1, 32'h10 + i - 1);
        chk("stream_ctrl1",  out_ctrl1, 8'h01);
        chk("stream_ready1", in_ready1, 1'b1);
        chk("stream_data0",  out_data0, 32'h10 + i - 1);
      end
    end
    tick(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

    // backpressure on both variants
    tick(1'b1, 8'h02, 32'hA0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 8'h02, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_head1",   out_data1, 32'hA0);
    chk("bp_ready1a", in_ready1, 1'b1);
    chk("bp_ready0",  in_ready0, 1'b0);
    tick(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_both_ready1", in_ready1, 1'b0);
    chk("bp_both_head1",  out_data1, 32'hA0);
    tick(1'b1, 8'h03, 32'hB0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_release0", in_ready0, 1'b1);
    tick(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_second1", out_data1, 32'hA1);
    chk("bp_load0",   out_data0, 32'hB0);
    tick(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

    // flush while holding two entries with a beat arriving
    tick(1'b1, 8'h04, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h04, 32'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'hFF, 32'hC2, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fl_both_ready1", in_ready1, 1'b0);
    tick(1'b1, 8'h01, 32'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fl_valid1", out_valid1, 1'b0);
    chk("fl_ctrl1",  out_ctrl1, 8'h00);
    chk("fl_ready1", in_ready1, 1'b1);
    tick(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fl_after_data1", out_data1, 32'h55);
    chk("fl_after_ctrl1", out_ctrl1, 8'h01);

    // stall counter saturation and clear
    tick(1'b1, 8'h05, 32'hD0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_sat1", stall1, 4'hF);
    chk("stall_sat0", stall0, 4'hF);
    tick(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_clr1", stall1, 4'h0);
    tick(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall_restart1", stall1, 4'h1);
    chk("stall_restart0", stall0, 4'h1);

    // asynchronous reset while full
    tick(1'b1, 8'h06, 32'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_valid1", out_valid1, 1'b0);
    chk("arst_ctrl1",  out_ctrl1, 8'h00);
    chk("arst_data1",  out_data1, 32'h0);
    chk("arst_stall1", stall1, 4'h0);
    chk("arst_ready1", in_ready1, 1'b1);
    chk("arst_ready0", in_ready0, 1'b1);
    chk("arst_data0",  out_data0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) != 0, 8'($urandom), 32'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end
    tick(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
